// File: rtl/bexkat1_pkg.sv
// Shared types and constants for the bexkat1 front end.
package bexkat1_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } ifetch_state_t;

  // Bit of an instruction's first word that marks a two-word instruction.
  localparam int INSN_LONG_BIT   = 0;
  localparam int INSN_WORD_BYTES = 4;

endpackage

// File: rtl/ifetch_fifo.sv
// Word queue for the prefetcher: one push, 0/1/2-word pop, peek of the two
// head entries, synchronous flush. Storage resets to zero so the head reads 0
// out of reset.
module ifetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic [1:0]       pop_n,
  output logic [WIDTH-1:0] head0,
  output logic [WIDTH-1:0] head1,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [AW-1:0]    rd_nxt;

  // Pointer, count and storage updates; flush wins over push/pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      rd_ptr_d = rd_ptr_q + AW'(pop_n);
      count_d  = count_q + CW'(push) - CW'(pop_n);
    end
  end

  // Queue state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_nxt = rd_ptr_q + AW'(1);
  assign head0  = mem_q[rd_ptr_q];
  assign head1  = mem_q[rd_nxt];
  assign count  = count_q;

endmodule

// File: rtl/ifetch_prefetch.sv
// Prefetching instruction fetch unit: streams words into a queue, assembles
// 32/64-bit instructions at the head and hands them to decode.
//
//   state | meaning
//   RUN   | normal fetch; words acked here are pushed into the queue
//   DRAIN | redirected with a request in flight; cyc held, stb low, the
//         | acked word is thrown away, then fetch restarts at fa
module ifetch_prefetch
  import bexkat1_pkg::*;
#(
  parameter int                AWIDTH   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pc_set,
  input  logic [AWIDTH-1:0] pc_in,
  input  logic              stall_i,
  output logic [63:0]       ir,
  output logic [AWIDTH-1:0] pc,
  output logic              ir_valid,
  output logic              stall_o,
  output logic              bus_cyc,
  output logic              bus_stb,
  output logic [AWIDTH-1:0] bus_adr,
  input  logic              bus_ack,
  input  logic [31:0]       bus_in
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AWIDTH-1:0] STEP1 = AWIDTH'(INSN_WORD_BYTES);
  localparam logic [AWIDTH-1:0] STEP2 = AWIDTH'(2 * INSN_WORD_BYTES);

  ifetch_state_t     state_q, state_d;
  logic [AWIDTH-1:0] fa_q, fa_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic [AWIDTH-1:0] adr_q, adr_d;

  logic [31:0]       head0, head1;
  logic [CW-1:0]     count, count_next;
  logic              head_long, consume, push;
  logic [1:0]        pop_n;
  logic [AWIDTH-1:0] target;

  ifetch_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_i),
    .flush     (pc_set),
    .push      (push),
    .push_data (bus_in),
    .pop_n     (pop_n),
    .head0     (head0),
    .head1     (head1),
    .count     (count)
  );

  // Head decode, consume/push qualification and the post-update queue count.
  always_comb begin
    head_long  = head0[INSN_LONG_BIT];
    ir_valid   = ((count != '0) && !head_long) || (count >= CW'(2));
    consume    = ir_valid && !stall_i && !pc_set;
    push       = (state_q == RUN) && cyc_q && stb_q && bus_ack && !pc_set;
    pop_n      = consume ? (head_long ? 2'd2 : 2'd1) : 2'd0;
    count_next = count + CW'(push) - CW'(pop_n);
    target     = pc_in & ~AWIDTH'(3);
  end

  // Fetch FSM: redirect handling, request issue and pc advance.
  always_comb begin
    state_d = state_q;
    fa_d    = fa_q;
    pc_d    = pc_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    adr_d   = adr_q;
    if (consume) pc_d = pc_q + (head_long ? STEP2 : STEP1);
    case (state_q)
      RUN: begin
        if (pc_set) begin
          pc_d = target;
          fa_d = target;
          if (cyc_q && !bus_ack) begin
            state_d = DRAIN;
            stb_d   = 1'b0;
          end else begin
            cyc_d = 1'b1;
            stb_d = 1'b1;
            adr_d = target;
          end
        end else begin
          if (push) fa_d = fa_q + STEP1;
          if (cyc_q && !bus_ack) begin
            // request still in flight: hold cyc/stb/adr
          end else if (count_next < CW'(DEPTH)) begin
            cyc_d = 1'b1;
            stb_d = 1'b1;
            adr_d = fa_d;
          end else begin
            cyc_d = 1'b0;
            stb_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (pc_set) begin
          pc_d = target;
          fa_d = target;
        end
        if (bus_ack) begin
          state_d = RUN;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          adr_d   = fa_d;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Fetch state registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= RUN;
      fa_q    <= RESET_PC;
      pc_q    <= RESET_PC;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      fa_q    <= fa_d;
      pc_q    <= pc_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      adr_q   <= adr_d;
    end
  end

  assign ir      = {head0, head_long ? head1 : 32'h0};
  assign pc      = pc_q;
  assign stall_o = !ir_valid;
  assign bus_cyc = cyc_q;
  assign bus_stb = stb_q;
  assign bus_adr = adr_q;

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Directed bench for ifetch_prefetch with a zero-wait / N-wait word memory.
module tb_ifetch_prefetch;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        pc_set = 1'b0;
  logic [31:0] pc_in = '0;
  logic        stall_i = 1'b0;
  logic [63:0] ir;
  logic [31:0] pc;
  logic        ir_valid, stall_o, bus_cyc, bus_stb, bus_ack;
  logic [31:0] bus_adr, bus_in;

  int vectors = 0;
  int errors  = 0;
  int ack_delay = 0;
  int wait_cnt;

  ifetch_prefetch #(.AWIDTH(32), .DEPTH(4), .RESET_PC(32'h100)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .pc_set   (pc_set),
    .pc_in    (pc_in),
    .stall_i  (stall_i),
    .ir       (ir),
    .pc       (pc),
    .ir_valid (ir_valid),
    .stall_o  (stall_o),
    .bus_cyc  (bus_cyc),
    .bus_stb  (bus_stb),
    .bus_adr  (bus_adr),
    .bus_ack  (bus_ack),
    .bus_in   (bus_in)
  );

  always #5 clk_i = ~clk_i;

  // Memory: each word holds its own address (short), except a long pair at 0x200.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h200) return 32'h0000_0001;
    if (a == 32'h204) return 32'hDEAD_BEEF;
    return a;
  endfunction

  assign bus_in  = mem_word(bus_adr);
  assign bus_ack = bus_cyc && (wait_cnt >= ack_delay);

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) wait_cnt <= 0;
    else if (!bus_cyc || bus_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #1 rst_i = 1'b0;
    #1;
    vectors++; if (bus_cyc !== 1'b0) begin errors++; $display("FAIL rst_cyc got %0b want 0", bus_cyc); end
    vectors++; if (bus_stb !== 1'b0) begin errors++; $display("FAIL rst_stb got %0b want 0", bus_stb); end
    vectors++; if (bus_adr !== 32'h0) begin errors++; $display("FAIL rst_adr got %h want 0", bus_adr); end
    vectors++; if (pc !== 32'h100) begin errors++; $display("FAIL rst_pc got %h want 100", pc); end
    vectors++; if (ir_valid !== 1'b0 || stall_o !== 1'b1) begin errors++; $display("FAIL rst_valid got v=%0b s=%0b want v=0 s=1", ir_valid, stall_o); end
    vectors++; if (ir !== 64'h0) begin errors++; $display("FAIL rst_ir got %h want 0", ir); end
    tick(); tick();
    rst_i = 1'b1;
    tick();
    vectors++; if (bus_cyc !== 1'b1 || bus_adr !== 32'h100) begin errors++; $display("FAIL first_req got cyc=%0b adr=%h want cyc=1 adr=100", bus_cyc, bus_adr); end
    vectors++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL first_valid got %0b want 0", ir_valid); end
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (ir_valid !== 1'b1 || pc !== 32'h100 + 4*k || ir !== {32'h100 + 32'(4*k), 32'h0} || bus_adr !== 32'h104 + 4*k) begin
        errors++;
        $display("FAIL stream%0d got v=%0b pc=%h ir=%h adr=%h want v=1 pc=%h adr=%h",
                 k, ir_valid, pc, ir, bus_adr, 32'h100 + 4*k, 32'h104 + 4*k);
      end
    end
  endtask

  task automatic test_redirect_ack();
    vectors++; if (ir_valid !== 1'b1 || bus_ack !== 1'b1) begin errors++; $display("FAIL redir_pre got v=%0b ack=%0b want 1 1", ir_valid, bus_ack); end
    pc_set = 1'b1; pc_in = 32'h303;
    tick();
    pc_set = 1'b0;
    vectors++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %0b want 0", ir_valid); end
    vectors++; if (pc !== 32'h300) begin errors++; $display("FAIL redir_pc got %h want 300", pc); end
    vectors++; if (bus_adr !== 32'h300 || bus_stb !== 1'b1) begin errors++; $display("FAIL redir_adr got adr=%h stb=%0b want 300 1", bus_adr, bus_stb); end
    tick();
    vectors++; if (ir_valid !== 1'b1 || ir !== 64'h0000_0300_0000_0000 || pc !== 32'h300) begin errors++; $display("FAIL redir_first got v=%0b ir=%h pc=%h want 1 0000030000000000 300", ir_valid, ir, pc); end
  endtask

  task automatic test_long();
    pc_set = 1'b1; pc_in = 32'h200;
    tick();
    pc_set = 1'b0;
    vectors++; if (ir_valid !== 1'b0 || bus_adr !== 32'h200) begin errors++; $display("FAIL long_redir got v=%0b adr=%h want 0 200", ir_valid, bus_adr); end
    tick();
    vectors++; if (ir_valid !== 1'b0 || stall_o !== 1'b1) begin errors++; $display("FAIL long_half got v=%0b s=%0b want 0 1", ir_valid, stall_o); end
    tick();
    vectors++; if (ir_valid !== 1'b1 || ir !== 64'h0000_0001_DEAD_BEEF || pc !== 32'h200) begin errors++; $display("FAIL long_ir got v=%0b ir=%h pc=%h want 1 00000001deadbeef 200", ir_valid, ir, pc); end
    tick();
    vectors++; if (ir_valid !== 1'b1 || pc !== 32'h208 || ir[63:32] !== 32'h208) begin errors++; $display("FAIL long_next got v=%0b pc=%h ir=%h want 1 208", ir_valid, pc, ir); end
  endtask

  task automatic test_stall_full();
    int acks = 0;
    stall_i = 1'b1;
    pc_set = 1'b1; pc_in = 32'h500;
    tick();
    pc_set = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus_ack) acks++;
      tick();
    end
    vectors++; if (acks !== 4) begin errors++; $display("FAIL full_acks got %0d want 4", acks); end
    vectors++; if (bus_cyc !== 1'b0) begin errors++; $display("FAIL full_cyc got %0b want 0", bus_cyc); end
    vectors++; if (ir_valid !== 1'b1 || pc !== 32'h500) begin errors++; $display("FAIL full_head got v=%0b pc=%h want 1 500", ir_valid, pc); end
    stall_i = 1'b0;
    tick();
    vectors++; if (bus_cyc !== 1'b1 || bus_adr !== 32'h510) begin errors++; $display("FAIL resume got cyc=%0b adr=%h want 1 510", bus_cyc, bus_adr); end
    vectors++; if (pc !== 32'h504) begin errors++; $display("FAIL resume_pc got %h want 504", pc); end
  endtask

  task automatic test_drain();
    logic        stale = 1'b0;
    logic        seen = 1'b0;
    logic [31:0] first_adr = '0;
    ack_delay = 3;
    #1;
    vectors++; if (bus_cyc !== 1'b1 || bus_ack !== 1'b0) begin errors++; $display("FAIL drain_pre got cyc=%0b ack=%0b want 1 0", bus_cyc, bus_ack); end
    pc_set = 1'b1; pc_in = 32'h400;
    tick();
    pc_set = 1'b0;
    vectors++; if (bus_cyc !== 1'b1 || bus_stb !== 1'b0) begin errors++; $display("FAIL drain_bus got cyc=%0b stb=%0b want 1 0", bus_cyc, bus_stb); end
    vectors++; if (ir_valid !== 1'b0 || pc !== 32'h400) begin errors++; $display("FAIL drain_pc got v=%0b pc=%h want 0 400", ir_valid, pc); end
    for (int i = 0; i < 30; i++) begin
      if (ir_valid && ir[63:32] == 32'h510) stale = 1'b1;
      if (bus_stb && !seen) begin seen = 1'b1; first_adr = bus_adr; end
      if (ir_valid) break;
      tick();
    end
    vectors++; if (seen !== 1'b1 || first_adr !== 32'h400) begin errors++; $display("FAIL drain_next got seen=%0b adr=%h want 1 400", seen, first_adr); end
    vectors++; if (stale !== 1'b0) begin errors++; $display("FAIL drain_stale got %0b want 0", stale); end
    vectors++; if (ir_valid !== 1'b1 || ir[63:32] !== 32'h400 || pc !== 32'h400) begin errors++; $display("FAIL drain_ir got v=%0b ir=%h pc=%h want 1 400 400", ir_valid, ir, pc); end
  endtask

  task automatic test_reset_mid();
    logic found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus_cyc && !bus_ack) begin found = 1'b1; break; end
      tick();
    end
    vectors++; if (found !== 1'b1) begin errors++; $display("FAIL mid_outstanding got %0b want 1", found); end
    #2 rst_i = 1'b0;
    #1;
    vectors++; if (bus_cyc !== 1'b0 || bus_stb !== 1'b0 || bus_adr !== 32'h0) begin errors++; $display("FAIL mid_bus got cyc=%0b stb=%0b adr=%h want 0 0 0", bus_cyc, bus_stb, bus_adr); end
    vectors++; if (ir_valid !== 1'b0 || stall_o !== 1'b1 || pc !== 32'h100 || ir !== 64'h0) begin errors++; $display("FAIL mid_out got v=%0b s=%0b pc=%h ir=%h want 0 1 100 0", ir_valid, stall_o, pc, ir); end
    tick();
    rst_i = 1'b1;
    ack_delay = 0;
    tick();
    vectors++; if (bus_cyc !== 1'b1 || bus_adr !== 32'h100) begin errors++; $display("FAIL restart got cyc=%0b adr=%h want 1 100", bus_cyc, bus_adr); end
    tick();
    vectors++; if (ir_valid !== 1'b1 || pc !== 32'h100 || ir[63:32] !== 32'h100) begin errors++; $display("FAIL restart_ir got v=%0b pc=%h ir=%h want 1 100 100", ir_valid, pc, ir); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_redirect_ack();
    test_long();
    test_stall_full();
    test_drain();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_prefetch.md
# ifetch_prefetch

Parametrised prefetching instruction fetch unit for the bexkat1 core; successor to the single-word fetch stage. Streams 32-bit words from a Wishbone-style instruction port into a DEPTH-entry queue, assembles 32- or 64-bit instructions at the queue head, and presents them to decode with a stall handshake. Sits between the pipeline front end and the instruction-side port of the dual-port RAM or bus arbiter.

## Interface
- AWIDTH, 32: byte-address width of bus_adr and the PC.
- DEPTH, 4: queue depth in 32-bit words; power of two, ≥ 2.
- RESET_PC, 0: fetch address after reset.

- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- pc_set  in  1  redirect: flush the queue and fetch from pc_in.
- pc_in  in  AWIDTH  redirect target; bits [1:0] ignored (treated as 0).
- stall_i  in  1  decode cannot accept ir this cycle.
- ir  out  64  instruction at queue head: [63:32] first word; [31:0] second word (long) or 0 (short).
- pc  out  AWIDTH  byte address of ir's first word.
- ir_valid  out  1  ir and pc are valid.
- stall_o  out  1  equals !ir_valid.
- bus_cyc  out  1  bus cycle active.
- bus_stb  out  1  request strobe.
- bus_adr  out  AWIDTH  word-aligned fetch address.
- bus_ack  in  1  request completed; bus_in valid.
- bus_in  in  32  read data.

## Operation
- Instruction length: a first word with bit 0 = 1 is long (two words); otherwise short.
- Internal: fetch address fa, queue (DEPTH × 32, count), state ∈ {RUN, DRAIN}.
- Issue (RUN): bus_cyc = bus_stb = 1 with bus_adr = fa while count < DEPTH (registered). At most one request is outstanding; cyc/stb/adr are held until bus_ack.
- On bus_ack in RUN: push bus_in and set fa += 4. If the queue is then full and no pop occurs, drop cyc/stb on the next cycle.
- ir_valid = (count ≥ 1 and head bit0 = 0) or (count ≥ 2). ir and pc are driven combinationally from the queue head registers.
- Consume: when ir_valid && !stall_i, pop 1 word (short) or 2 words (long) and set pc += 4 or += 8.
- Push and pop in the same cycle are legal; count changes by pushed − popped words.
- Redirect: pc_set overrides consume and push.
  - Queue is emptied; pc = fa = {pc_in[AWIDTH-1:2], 2'b00}; ir_valid = 0 next cycle.
  - If a request is outstanding and bus_ack is not present that cycle: go to DRAIN, keep cyc high and stb low until bus_ack, discard that data, then return to RUN.
  - If bus_ack is present in the same cycle as pc_set: discard the data and stay in RUN.
- pc_set during DRAIN updates pc and fa only; DRAIN continues.
- Arithmetic: pc and fa wrap modulo 2^AWIDTH. The queue pointers wrap modulo DEPTH.

## Timing
- Reset (async assert): bus_cyc = bus_stb = 0, bus_adr = 0, pc = fa = RESET_PC, count = 0, ir_valid = 0, stall_o = 1, ir = 0, state = RUN.
- After reset deasserts: first request is issued on the first clock edge (bus_adr = RESET_PC).
- pc_set sampled at edge N: request for pc_in is on the bus from N+1 (RUN case).
- bus_ack at edge M: word is in the queue and ir_valid rises after M (visible in cycle M+1).
- With a 1-cycle-ack memory, a short instruction at the redirect target is valid 2 cycles after pc_set.
- Sustained throughput is one word per ack. A full queue with decode stalled holds bus_cyc low.
- A long head instruction with only one word queued keeps ir_valid = 0 until the second word arrives.
- Reset mid-cycle: the outstanding bus cycle is abandoned and cyc drops asynchronously.

## Structure
- Shared package bexkat1_pkg holds:
  - the ifetch_state_t enum (RUN, DRAIN);
  - INSN_LONG_BIT = 0;
  - INSN_WORD_BYTES = 4.
- Sub-module ifetch_fifo (parametrised DEPTH/WIDTH synchronous FIFO): 1- or 2-word pop, peek of head and head+1, count output, flush input.

## Test plan
- Reset with RESET_PC = 0x100, 1-cycle-ack RAM of short words → bus_adr 0x100, 0x104, …; ir_valid from cycle 2; pc steps by 4 each cycle.
- Word 0x00000001 then 0xDEADBEEF at 0x200 → single ir = 0x00000001DEADBEEF, pc = 0x200; next pc = 0x208.
- stall_i held high with DEPTH = 4 → exactly 4 acks, then bus_cyc = 0. Release stall → fetch resumes at fa = base + 16.
- pc_set to 0x400 while the ack is delayed 3 cycles → DRAIN; late data discarded; next bus_adr = 0x400; ir never shows the stale word.
- pc_set coincident with bus_ack and a consume → data and pop discarded; pc = target; ir_valid = 0 the next cycle.
- Assert rst_i low during an outstanding request → all outputs reach reset values immediately. After release, fetch restarts at RESET_PC.
